// File: rtl/shape_pkg.sv
// ---------------------------------------------------------------------------
// shape_pkg
//
// Shared types and constants for the shape record engine.
//   shape_op_t    : request opcode carried on req_op
//   FIELD_*       : word index of each named field inside a record slot
//   shape_state_t : engine sequencing states
//   op_writes()   : true for opcodes that drive the RAM write strobe
// ---------------------------------------------------------------------------
package shape_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } shape_op_t;

    // Word offsets of the named fields within a record slot
    localparam int FIELD_TY     = 0;
    localparam int FIELD_X      = 1;
    localparam int FIELD_Y      = 2;
    localparam int FIELD_SIZE   = 3;
    localparam int FIELD_ROTATE = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } shape_state_t;

    // CLEAR shares the write sequence; it only differs in the data it drives
    function automatic logic op_writes(input shape_op_t op);
        return (op == OP_WRITE) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/shape_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// shape_rd_tag_pipe
//
// RDLAT-deep shift register that travels alongside each RAM read strobe, so
// the word arriving RDLAT cycles later can be steered to the right field
// register. Cleared synchronously so an aborted read never captures.
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset, empties the pipe
//   strobe     : read strobe issued this cycle
//   strobe_idx : field index of the strobed word
//   tag_valid  : returned word on ram_rd_data is a requested field
//   tag_idx    : field index of the returned word
// ---------------------------------------------------------------------------
module shape_rd_tag_pipe #(
    parameter int RDLAT = 1,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strobe,
    input  logic [IDXW-1:0] strobe_idx,
    output logic            tag_valid,
    output logic [IDXW-1:0] tag_idx
);

    logic            valid_sr [RDLAT];
    logic [IDXW-1:0] idx_sr   [RDLAT];

    // Stage 0 takes the strobe; the last stage lines up with the RAM data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RDLAT; i++) begin
                valid_sr[i] <= 1'b0;
                idx_sr[i]   <= '0;
            end
        end else begin
            valid_sr[0] <= strobe;
            idx_sr[0]   <= strobe_idx;
            for (int i = 1; i < RDLAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                idx_sr[i]   <= idx_sr[i-1];
            end
        end
    end

    assign tag_valid = valid_sr[RDLAT-1];
    assign tag_idx   = idx_sr[RDLAT-1];

endmodule

// File: rtl/shape_record_port.sv
// ---------------------------------------------------------------------------
// shape_record_port
//
// Record engine between the shape controller and the shape-table RAM. Takes
// one WRITE / READ / CLEAR / NOP request at a time over valid/ready and walks
// the first NFIELD words of the record slot at
//   (id << DATAB) + ram_address_offset   (mod 2^ADDRW).
// Field order in a slot: ty, x, y, size, rotate; extra words are zero.
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid / req_ready      : request handshake
//   req_op                     : shape_op_t opcode
//   id, ram_address_offset     : record index and table base
//   ty, x, y, size, rotate     : field values for WRITE
//   ram_address                : shared read/write word address
//   ram_enable, ram_data       : write strobe and data
//   ram_rd_enable, ram_rd_data : read strobe and data (RDLAT cycles later)
//   rd_ty .. rd_rotate         : fields of the most recent read
//   done                       : one-cycle completion pulse
//   busy                       : inverse of req_ready
// ---------------------------------------------------------------------------
module shape_record_port
    import shape_pkg::*;
#(
    parameter int DATAB  = 3,
    parameter int NFIELD = 5,
    parameter int CORDW  = 10,
    parameter int ADDRW  = 20,
    parameter int DATAW  = 12,
    parameter int NUMW   = DATAW,
    parameter int RDLAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [NUMW-1:0]  id,
    input  logic [ADDRW-1:0] ram_address_offset,
    input  logic [DATAW-1:0] ty,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    input  logic [DATAW-1:0] size,
    input  logic [DATAW-1:0] rotate,
    output logic [ADDRW-1:0] ram_address,
    output logic             ram_enable,
    output logic [DATAW-1:0] ram_data,
    output logic             ram_rd_enable,
    input  logic [DATAW-1:0] ram_rd_data,
    output logic [DATAW-1:0] rd_ty,
    output logic [CORDW-1:0] rd_x,
    output logic [CORDW-1:0] rd_y,
    output logic [DATAW-1:0] rd_size,
    output logic [DATAW-1:0] rd_rotate,
    output logic             done,
    output logic             busy
);

    // One extra bit so ptr can hold 2^DATAB-1 even when DATAB is 0
    localparam int PTRW  = DATAB + 1;
    localparam int WIDEW = ADDRW + NUMW + DATAB;
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(NFIELD - 1);

    shape_state_t     state;
    logic [PTRW-1:0]  ptr;
    logic [PTRW-1:0]  ptr_next;
    logic             clear_op;
    logic [ADDRW-1:0] base;
    logic [ADDRW-1:0] base_in;
    logic [DATAW-1:0] ty_q;
    logic [CORDW-1:0] x_q;
    logic [CORDW-1:0] y_q;
    logic [DATAW-1:0] size_q;
    logic [DATAW-1:0] rotate_q;
    logic [DATAW-1:0] next_word;
    logic             accept;
    logic             tag_valid;
    logic [PTRW-1:0]  tag_idx;
    shape_op_t        op_in;

    assign op_in    = shape_op_t'(req_op);
    assign accept   = req_valid && req_ready;
    assign ptr_next = ptr + PTRW'(1);
    assign busy     = !req_ready;

    // Widen before shifting so high id bits are dropped only by the final
    // truncation, giving a clean mod 2^ADDRW wrap
    assign base_in = ADDRW'(WIDEW'(id) << DATAB) + ram_address_offset;

    // Data for the word after the current one, taken from the latched fields
    always_comb begin
        next_word = '0;
        if (!clear_op) begin
            case (ptr_next)
                PTRW'(FIELD_TY):     next_word = ty_q;
                PTRW'(FIELD_X):      next_word = DATAW'(x_q);
                PTRW'(FIELD_Y):      next_word = DATAW'(y_q);
                PTRW'(FIELD_SIZE):   next_word = size_q;
                PTRW'(FIELD_ROTATE): next_word = rotate_q;
                default:             next_word = '0;
            endcase
        end
    end

    // Main sequencer. All RAM-side outputs are registered: the values for
    // word ptr+1 are loaded on the same edge that advances ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            clear_op      <= 1'b0;
            base          <= '0;
            ty_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            size_q        <= '0;
            rotate_q      <= '0;
            req_ready     <= 1'b1;
            done          <= 1'b0;
            ram_enable    <= 1'b0;
            ram_rd_enable <= 1'b0;
            ram_address   <= '0;
            ram_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr       <= '0;
                        base      <= base_in;
                        clear_op  <= (op_in == OP_CLEAR);
                        ty_q      <= ty;
                        x_q       <= x;
                        y_q       <= y;
                        size_q    <= size;
                        rotate_q  <= rotate;
                        req_ready <= 1'b0;
                        if (op_writes(op_in)) begin
                            state       <= WRITE;
                            ram_enable  <= 1'b1;
                            ram_address <= base_in;
                            ram_data    <= (op_in == OP_CLEAR) ? '0 : ty;
                        end else if (op_in == OP_READ) begin
                            state         <= READ;
                            ram_rd_enable <= 1'b1;
                            ram_address   <= base_in;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (ptr == LAST_PTR) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        ram_enable  <= 1'b0;
                        ram_address <= '0;
                        ram_data    <= '0;
                    end else begin
                        ptr         <= ptr_next;
                        ram_address <= base + ADDRW'(ptr_next);
                        ram_data    <= next_word;
                    end
                end

                READ: begin
                    if (ptr == LAST_PTR) begin
                        state         <= DRAIN;
                        ram_rd_enable <= 1'b0;
                        ram_address   <= '0;
                    end else begin
                        ptr         <= ptr_next;
                        ram_address <= base + ADDRW'(ptr_next);
                    end
                end

                // The last field's tag surfacing means its data is on the bus now
                DRAIN: begin
                    if (tag_valid && (tag_idx == LAST_PTR)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Read-back registers only change on a tagged capture; slots beyond the
    // named fields are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ty     <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_size   <= '0;
            rd_rotate <= '0;
        end else if (tag_valid) begin
            case (tag_idx)
                PTRW'(FIELD_TY):     rd_ty     <= ram_rd_data;
                PTRW'(FIELD_X):      rd_x      <= ram_rd_data[CORDW-1:0];
                PTRW'(FIELD_Y):      rd_y      <= ram_rd_data[CORDW-1:0];
                PTRW'(FIELD_SIZE):   rd_size   <= ram_rd_data;
                PTRW'(FIELD_ROTATE): rd_rotate <= ram_rd_data;
                default: ;
            endcase
        end
    end

    shape_rd_tag_pipe #(
        .RDLAT (RDLAT),
        .IDXW  (PTRW)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .strobe     (ram_rd_enable),
        .strobe_idx (ptr),
        .tag_valid  (tag_valid),
        .tag_idx    (tag_idx)
    );

endmodule

// File: tb/tb_shape_record_port.sv
// ---------------------------------------------------------------------------
// tb_shape_record_port
//
// Scoreboard bench for shape_record_port. The driver pushes expected RAM
// writes, read addresses and completion records at accept time; a negedge
// monitor pops and compares as the DUT produces them. A word-addressed
// dictionary holds what the table should contain after each operation.
// ---------------------------------------------------------------------------
module tb_shape_record_port;
    import shape_pkg::*;

    localparam int DATAB  = 3;
    localparam int NFIELD = 5;
    localparam int CORDW  = 10;
    localparam int ADDRW  = 20;
    localparam int DATAW  = 12;
    localparam int NUMW   = 12;
    localparam int RDLAT  = 2;
    localparam int SLOT   = 1 << DATAB;
    localparam int AMASK  = (1 << ADDRW) - 1;
    localparam int CMASK  = (1 << CORDW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [NUMW-1:0]  id = '0;
    logic [ADDRW-1:0] ram_address_offset = '0;
    logic [DATAW-1:0] ty = '0;
    logic [CORDW-1:0] x = '0;
    logic [CORDW-1:0] y = '0;
    logic [DATAW-1:0] size = '0;
    logic [DATAW-1:0] rotate = '0;
    logic [ADDRW-1:0] ram_address;
    logic             ram_enable;
    logic [DATAW-1:0] ram_data;
    logic             ram_rd_enable;
    logic [DATAW-1:0] ram_rd_data;
    logic [DATAW-1:0] rd_ty;
    logic [CORDW-1:0] rd_x;
    logic [CORDW-1:0] rd_y;
    logic [DATAW-1:0] rd_size;
    logic [DATAW-1:0] rd_rotate;
    logic             done;
    logic             busy;

    always #5 clk = ~clk;

    shape_record_port #(
        .DATAB(DATAB), .NFIELD(NFIELD), .CORDW(CORDW), .ADDRW(ADDRW),
        .DATAW(DATAW), .NUMW(NUMW), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .id(id), .ram_address_offset(ram_address_offset),
        .ty(ty), .x(x), .y(y), .size(size), .rotate(rotate),
        .ram_address(ram_address), .ram_enable(ram_enable), .ram_data(ram_data),
        .ram_rd_enable(ram_rd_enable), .ram_rd_data(ram_rd_data),
        .rd_ty(rd_ty), .rd_x(rd_x), .rd_y(rd_y), .rd_size(rd_size),
        .rd_rotate(rd_rotate), .done(done), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM behavioural model with RDLAT-cycle read latency; junk when idle
    logic [DATAW-1:0] ram [int];
    logic [DATAW-1:0] rd_pipe [RDLAT];

    always @(posedge clk) begin
        if (ram_enable) ram[int'(ram_address)] = ram_data;
    end

    always @(posedge clk) begin
        for (int i = RDLAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_rd_enable)
            rd_pipe[0] <= ram.exists(int'(ram_address)) ? ram[int'(ram_address)] : '0;
        else
            rd_pipe[0] <= DATAW'($urandom);
    end

    assign ram_rd_data = rd_pipe[RDLAT-1];

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0]             acc;
        logic [31:0]             lat;
        logic [4:0][DATAW-1:0]   f;
    } done_t;

    wr_t                   wq [$];
    logic [ADDRW-1:0]      rq [$];
    done_t                 dq [$];
    int                    exp_mem [int];
    logic [4:0][DATAW-1:0] last_rd = '0;
    bit                    ignore_strobes = 1'b0;
    int                    last_done_cyc = -100;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    function automatic int modelWord(input int a);
        return exp_mem.exists(a) ? exp_mem[a] : 0;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT shows a strobe or done
    always @(negedge clk) begin
        wr_t   we;
        done_t de;
        if (!rst) begin
            if (ram_enable || ram_rd_enable)
                checkOutput("strobe_exclusive", {31'b0, ram_enable & ram_rd_enable}, 32'd0);
            if (ram_enable && !ignore_strobes) begin
                if (wq.size() == 0) flagFail("unexpected_write");
                else begin
                    we = wq.pop_front();
                    checkOutput("write_addr", 32'(ram_address), 32'(we.addr));
                    checkOutput("write_data", 32'(ram_data), 32'(we.data));
                end
            end
            if (ram_rd_enable && !ignore_strobes) begin
                if (rq.size() == 0) flagFail("unexpected_read");
                else checkOutput("read_addr", 32'(ram_address), 32'(rq.pop_front()));
            end
            if (done) begin
                last_done_cyc = cyc;
                checkOutput("ready_low_in_done", {31'b0, req_ready}, 32'd0);
                if (dq.size() == 0) flagFail("unexpected_done");
                else begin
                    de = dq.pop_front();
                    checkOutput("done_latency", 32'(cyc) - de.acc, de.lat);
                    checkOutput("rd_ty", 32'(rd_ty), 32'(de.f[0]));
                    checkOutput("rd_x", 32'(rd_x), 32'(de.f[1]) & CMASK);
                    checkOutput("rd_y", 32'(rd_y), 32'(de.f[2]) & CMASK);
                    checkOutput("rd_size", 32'(rd_size), 32'(de.f[3]));
                    checkOutput("rd_rotate", 32'(rd_rotate), 32'(de.f[4]));
                end
            end
        end
    end

    // Drives one request, records the accept cycle and pushes expectations.
    // Returns #1 after the accept edge; inputs are scrambled unless held.
    task automatic applyStimulus(input int op, input int rid, input int off,
                                 input int f0, input int f1, input int f2,
                                 input int f3, input int f4,
                                 input bit hold, input bit poke_x, input bit track);
        int                    waited;
        int                    acc;
        int                    base;
        int                    a;
        int                    val;
        logic [4:0][DATAW-1:0] fl;
        done_t                 d;
        wr_t                   w;
        waited = 0;
        req_op = 2'(op);
        id = NUMW'(rid);
        ram_address_offset = ADDRW'(off);
        ty = DATAW'(f0);
        x = CORDW'(f1);
        y = CORDW'(f2);
        size = DATAW'(f3);
        rotate = DATAW'(f4);
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready) begin
            waited++;
            if (waited > 200) begin
                flagFail("accept_timeout");
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        acc = cyc;
        if (track && waited > 0) checkOutput("b2b_accept_cycle", 32'(acc), 32'(last_done_cyc + 1));
        if (track) begin
            base = (rid * SLOT + off) & AMASK;
            fl[0] = DATAW'(f0);
            fl[1] = DATAW'(f1 & CMASK);
            fl[2] = DATAW'(f2 & CMASK);
            fl[3] = DATAW'(f3);
            fl[4] = DATAW'(f4);
            d.acc = 32'(acc);
            if (op == 0 || op == 2) begin
                for (int i = 0; i < NFIELD; i++) begin
                    a = (base + i) & AMASK;
                    val = (op == 2 || i >= 5) ? 0 : int'(fl[i]);
                    w.addr = ADDRW'(a);
                    w.data = DATAW'(val);
                    wq.push_back(w);
                    exp_mem[a] = val;
                end
                d.lat = 32'(NFIELD + 1);
            end else if (op == 1) begin
                for (int i = 0; i < NFIELD; i++) begin
                    a = (base + i) & AMASK;
                    rq.push_back(ADDRW'(a));
                    if (i < 5) last_rd[i] = DATAW'(modelWord(a));
                end
                d.lat = 32'(NFIELD + RDLAT + 1);
            end else begin
                d.lat = 32'd1;
            end
            d.f = last_rd;
            dq.push_back(d);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_op = 2'($urandom);
            id = NUMW'($urandom);
            ram_address_offset = ADDRW'($urandom);
            ty = DATAW'($urandom);
            x = CORDW'($urandom);
            y = CORDW'($urandom);
            size = DATAW'($urandom);
            rotate = DATAW'($urandom);
        end
        if (poke_x) x = '0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((dq.size() != 0 || wq.size() != 0 || rq.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) flagFail("drain_timeout");
    endtask

    task automatic randomOps(input int count);
        int op;
        int rid;
        int off;
        int sel;
        bit hold;
        for (int k = 0; k < count; k++) begin
            op = $urandom_range(0, 3);
            rid = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 15);
            sel = $urandom_range(0, 2);
            off = (sel == 0) ? 'h100 : (sel == 1) ? 'hFFFF8 : 'h40;
            hold = 1'($urandom_range(0, 1));
            applyStimulus(op, rid, off, $urandom_range(0, 4095), $urandom_range(0, 4095),
                          $urandom_range(0, 4095), $urandom_range(0, 4095),
                          $urandom_range(0, 4095), hold, 1'b0, 1'b1);
            if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_strobes", {30'b0, ram_enable, ram_rd_enable}, 32'd0);
        checkOutput("reset_ram_address", 32'(ram_address), 32'd0);
        checkOutput("reset_ram_data", 32'(ram_data), 32'd0);
        checkOutput("reset_rd_fields", {31'b0, |{rd_ty, rd_x, rd_y, rd_size, rd_rotate}}, 32'd0);
        rst = 1'b0;

        $display("[TB] directed write with x changed after accept, then read");
        applyStimulus(0, 3, 'h100, 7, 'h3FF, 5, 9, 2, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(1, 3, 'h100, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] reset during a read");
        ignore_strobes = 1'b1;
        applyStimulus(1, 3, 'h100, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_strobes", {30'b0, ram_enable, ram_rd_enable}, 32'd0);
        checkOutput("abort_rd_cleared", {31'b0, |{rd_ty, rd_x, rd_y, rd_size, rd_rotate}}, 32'd0);
        repeat (RDLAT + 4) begin @(posedge clk); #1; end
        checkOutput("abort_no_late_capture", {31'b0, |{rd_ty, rd_x, rd_y, rd_size, rd_rotate}}, 32'd0);
        ignore_strobes = 1'b0;
        last_rd = '0;

        $display("[TB] read again, clear, read back-to-back");
        applyStimulus(1, 3, 'h100, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(2, 3, 'h100, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 3, 'h100, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] back-to-back write/read, address wrap, nop");
        applyStimulus(0, 5, 'h200, 'h123, 'h2AB, 'h011, 'hFED, 'h800, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 5, 'h200, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 3, 'hFFFF8, 'hA5A, 'h155, 'h2AA, 'h5A5, 'hFFF, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 3, 'hFFFF8, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(3, 9, 'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] randomized traffic");
        randomOps(80);
        waitIdle();
        checkOutput("final_done_queue", 32'(dq.size()), 32'd0);
        checkOutput("final_write_queue", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
